exp5_captura_jogada: RTL and testbench
======================================

EXP5_CAPTURA_JOGADA -- requirements
Module: exp5_captura_jogada

Interface
Parameters:
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 5, giving the number of consecutive stable synchronized cycles required to accept a press or a release; legal range >= 2.
Ports:
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port botoes, input, 4 bits: raw asynchronous push-buttons, active-high.
REQ-005 SHALL have port habilita, input, 1 bit: when high, a new capture may start.
REQ-006 SHALL have port jogada, output, 1 bit: one-cycle pulse marking an accepted single-button press; feeds the control unit's jogada input.
REQ-007 SHALL have port jogada_valor, output, 4 bits: one-hot code of the last accepted button, held until the next accepted press.
REQ-008 SHALL have port erro_multiplo, output, 1 bit: one-cycle pulse marking a debounced press that is not one-hot.
REQ-009 SHALL have port db_estado, output, 4 bits: current FSM state code, for the hex display.

Function
REQ-010 SHALL pass each botoes bit through a 2-flip-flop synchronizer; all further logic SHALL use only the synchronized vector (sinc).
REQ-011 SHALL implement a Moore FSM with state codes OCIOSO=0, FILTRA_PRESS=1, EMITE=2, SEGURA=3, FILTRA_SOLTA=4; any other code SHALL go to OCIOSO and display db_estado=F.
REQ-012 In OCIOSO, if sinc!=0 and habilita=1, SHALL latch candidato<=sinc, clear the counter, and go to FILTRA_PRESS; otherwise SHALL stay in OCIOSO.
REQ-013 In FILTRA_PRESS, if sinc!=candidato, SHALL return to OCIOSO (bounce); else if counter==DEBOUNCE_CYCLES-1, SHALL go to EMITE; else SHALL increment the counter.
REQ-014 In EMITE (exactly one cycle): if candidato is one-hot, SHALL drive jogada=1 and load jogada_valor<=candidato; otherwise SHALL drive erro_multiplo=1 and leave jogada_valor unchanged; next state SHALL be SEGURA.
REQ-015 In SEGURA, SHALL ignore all button changes while sinc!=0; on sinc==0 SHALL clear the counter and go to FILTRA_SOLTA.
REQ-016 In FILTRA_SOLTA, if sinc!=0, SHALL return to SEGURA; else if counter==DEBOUNCE_CYCLES-1, SHALL go to OCIOSO; else SHALL increment the counter.
REQ-017 Latency: with botoes stable from before rising edge E0, jogada SHALL be high exactly during the cycle after edge E0+DEBOUNCE_CYCLES+2.
REQ-018 habilita SHALL gate only the OCIOSO exit; a capture already in progress SHALL complete if habilita falls.
REQ-019 jogada and erro_multiplo SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted press.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap.

Reset
REQ-021 While reset=0, SHALL immediately force the synchronizer flops to 0, the state to OCIOSO, candidato and the counter to 0, jogada=0, erro_multiplo=0, jogada_valor=0000, db_estado=0, including when reset is asserted mid-capture.
REQ-022 After reset is released, a button already held SHALL be treated as a new press.

Structure
REQ-023 The state codes and the default DEBOUNCE_CYCLES SHALL be defined in the shared exp5 package.
REQ-024 The synchronizer SHALL be a separate sub-module, exp5_sincronizador, parameterized by width and instantiated with width 4.

Verification (DEBOUNCE_CYCLES=5)
REQ-025 Clean press: botoes=0010 held for 20 cycles -> exactly one jogada pulse after edge E0+7; jogada_valor=0010; db_estado 0->1->2->3.
REQ-026 Bounce: botoes=0100 for 3 cycles, then 0000 for 1 cycle, then 0100 stable -> exactly one jogada pulse, timed from the start of the final stable interval.
REQ-027 Multiple press: botoes=0011 stable, with jogada_valor=0010 beforehand -> one erro_multiplo pulse, no jogada pulse, jogada_valor stays 0010.
REQ-028 Hold, then add and release: while 0001 is held, 1001 is pressed, then release bounces 0000/0001/0000 -> no second pulse; the FSM returns to 0 only after 5 stable released cycles.
REQ-029 Gating and reset: habilita=0 with a press -> no pulse, db_estado=0; reset=0 asserted during FILTRA_PRESS -> all outputs 0 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/exp5_pkg.sv
// Shared definitions for the exp5 button-capture block.
// Contents:
//   DEBOUNCE_DEFAULT - default number of stable cycles that accept a press or a release
//   state codes      - FSM encodings, also shown on the hex display
//   DB_INVALIDO      - display code used when the state register holds an illegal value
//   is_one_hot()     - true when exactly one bit of a 4-bit vector is set
package exp5_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT = 5;

   localparam logic [2:0] OCIOSO       = 3'd0;
   localparam logic [2:0] FILTRA_PRESS = 3'd1;
   localparam logic [2:0] EMITE        = 3'd2;
   localparam logic [2:0] SEGURA       = 3'd3;
   localparam logic [2:0] FILTRA_SOLTA = 3'd4;

   localparam logic [3:0] DB_INVALIDO = 4'hF;

   function automatic logic is_one_hot(input logic [3:0] v);
      // Clearing the lowest set bit leaves zero only when a single bit was set.
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/exp5_sincronizador.sv
// Two-flop synchronizer for a vector of unrelated asynchronous inputs.
// Ports:
//   clock   - sampling clock
//   reset   - asynchronous active-low reset, clears both flop stages
//   entrada - raw asynchronous inputs
//   saida   - inputs re-timed to clock (two cycles of latency)
module exp5_sincronizador #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] entrada,
   output logic [WIDTH-1:0] saida
);

   logic [WIDTH-1:0] estagio1;
   logic [WIDTH-1:0] estagio2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estagio1 <= '0;
         estagio2 <= '0;
      end else begin
         estagio1 <= entrada;
         estagio2 <= estagio1;
      end
   end

   assign saida = estagio2;

endmodule

// File: rtl/exp5_captura_jogada.sv
// Debounced capture of a single push-button press for the exp5 game.
// Ports:
//   clock         - single clock, rising edge
//   reset         - asynchronous active-low reset
//   botoes        - raw push-buttons, active-high
//   habilita      - allows a new capture to start from idle
//   jogada        - one-cycle pulse for an accepted single-button press
//   jogada_valor  - one-hot code of the last accepted button
//   erro_multiplo - one-cycle pulse for a debounced press with several buttons
//   db_estado     - current FSM state code (F when the state is illegal)
module exp5_captura_jogada
   import exp5_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita,
   output logic       jogada,
   output logic [3:0] jogada_valor,
   output logic       erro_multiplo,
   output logic [3:0] db_estado
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    sinc;
   logic [2:0]    estado, estado_prox;
   logic [3:0]    candidato, candidato_prox;
   logic [CW-1:0] contador, contador_prox;
   logic [3:0]    valor, valor_prox;
   logic          emite;

   exp5_sincronizador #(
      .WIDTH(4)
   ) u_sincronizador (
      .clock  (clock),
      .reset  (reset),
      .entrada(botoes),
      .saida  (sinc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= OCIOSO;
         candidato <= 4'b0000;
         contador  <= '0;
         valor     <= 4'b0000;
      end else begin
         estado    <= estado_prox;
         candidato <= candidato_prox;
         contador  <= contador_prox;
         valor     <= valor_prox;
      end
   end

   always_comb begin
      estado_prox    = estado;
      candidato_prox = candidato;
      contador_prox  = contador;
      valor_prox     = valor;
      case (estado)
         OCIOSO: begin
            if ((sinc != 4'b0000) && habilita) begin
               candidato_prox = sinc;
               contador_prox  = '0;
               estado_prox    = FILTRA_PRESS;
            end
         end
         FILTRA_PRESS: begin
            if (sinc != candidato) begin
               estado_prox = OCIOSO;
            end else if (contador == CONT_MAX) begin
               estado_prox = EMITE;
            end else begin
               contador_prox = contador + CW'(1);
            end
         end
         EMITE: begin
            // A multi-button press is reported but never replaces the last valid move.
            if (is_one_hot(candidato)) begin
               valor_prox = candidato;
            end
            estado_prox = SEGURA;
         end
         SEGURA: begin
            if (sinc == 4'b0000) begin
               contador_prox = '0;
               estado_prox   = FILTRA_SOLTA;
            end
         end
         FILTRA_SOLTA: begin
            if (sinc != 4'b0000) begin
               estado_prox = SEGURA;
            end else if (contador == CONT_MAX) begin
               estado_prox = OCIOSO;
            end else begin
               contador_prox = contador + CW'(1);
            end
         end
         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

   assign emite         = (estado == EMITE);
   assign jogada        = emite && is_one_hot(candidato);
   assign erro_multiplo = emite && !is_one_hot(candidato);
   assign jogada_valor  = valor;

   always_comb begin
      if (estado <= FILTRA_SOLTA) begin
         db_estado = {1'b0, estado};
      end else begin
         db_estado = DB_INVALIDO;
      end
   end

endmodule

// File: tb/tb_exp5_captura_jogada.sv
module tb_exp5_captura_jogada;

   localparam int D = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] botoes = 4'b0000;
   logic       habilita = 1'b1;
   logic       jogada;
   logic [3:0] jogada_valor;
   logic       erro_multiplo;
   logic [3:0] db_estado;

   int total = 0;
   int bad = 0;

   exp5_captura_jogada #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .habilita     (habilita),
      .jogada       (jogada),
      .jogada_valor (jogada_valor),
      .erro_multiplo(erro_multiplo),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   // Reference model in run-length terms: a press is accepted after the
   // synchronized value matches for D+1 consecutive edges starting from a
   // free, enabled edge; afterwards the block is busy until D+1 consecutive
   // zero edges have been seen.
   logic [3:0] m_s0, m_s1, m_cand, m_valor;
   logic       m_capt, m_emit, m_hold;
   int         m_run, m_zrun;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_s0 <= 4'b0; m_s1 <= 4'b0; m_cand <= 4'b0; m_valor <= 4'b0;
         m_capt <= 1'b0; m_emit <= 1'b0; m_hold <= 1'b0; m_run <= 0; m_zrun <= 0;
      end else begin
         m_s0 <= botoes;
         m_s1 <= m_s0;
         if (m_emit) begin
            if ($countones(m_cand) == 1) m_valor <= m_cand;
            m_emit <= 1'b0;
            m_hold <= 1'b1;
            m_zrun <= 0;
         end else if (m_hold) begin
            if (m_s1 != 4'b0) m_zrun <= 0;
            else if (m_zrun == D) m_hold <= 1'b0;
            else m_zrun <= m_zrun + 1;
         end else if (m_capt) begin
            if (m_s1 != m_cand) m_capt <= 1'b0;
            else if (m_run == D) begin
               m_capt <= 1'b0;
               m_emit <= 1'b1;
            end else m_run <= m_run + 1;
         end else if (m_s1 != 4'b0 && habilita) begin
            m_cand <= m_s1;
            m_capt <= 1'b1;
            m_run  <= 1;
         end
      end
   end

   wire exp_jogada = m_emit && ($countones(m_cand) == 1);
   wire exp_erro   = m_emit && ($countones(m_cand) != 1);

   task automatic test_reset();
      reset = 1'b0;
      botoes = 4'b0000;
      habilita = 1'b1;
      repeat (3) @(negedge clock);
      total++; if (jogada !== 1'b0) begin bad++; $display("FAIL reset_jogada got=%b want=0", jogada); end
      total++; if (erro_multiplo !== 1'b0) begin bad++; $display("FAIL reset_erro got=%b want=0", erro_multiplo); end
      total++; if (jogada_valor !== 4'b0000) begin bad++; $display("FAIL reset_valor got=%b want=0000", jogada_valor); end
      total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL reset_db got=%h want=0", db_estado); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      botoes = 4'b0010;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (jogada) pulses++;
         total++;
         if (jogada !== (i == 8)) begin
            bad++; $display("FAIL clean_jogada cycle=%0d got=%b want=%b", i, jogada, (i == 8));
         end
         if (i == 2 || i == 3 || i == 8 || i == 9) begin
            logic [3:0] want;
            want = (i == 2) ? 4'h0 : (i == 3) ? 4'h1 : (i == 8) ? 4'h2 : 4'h3;
            total++;
            if (db_estado !== want) begin
               bad++; $display("FAIL clean_db cycle=%0d got=%h want=%h", i, db_estado, want);
            end
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL clean_pulses got=%0d want=1", pulses); end
      total++; if (jogada_valor !== 4'b0010) begin bad++; $display("FAIL clean_valor got=%b want=0010", jogada_valor); end
      botoes = 4'b0000;
      repeat (12) @(negedge clock);
      total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL clean_idle got=%h want=0", db_estado); end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      botoes = 4'b0100; repeat (3) @(negedge clock);
      botoes = 4'b0000; @(negedge clock);
      botoes = 4'b0100;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (jogada) pulses++;
         total++;
         if (jogada !== (i == 8)) begin
            bad++; $display("FAIL bounce_jogada cycle=%0d got=%b want=%b", i, jogada, (i == 8));
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", pulses); end
      total++; if (jogada_valor !== 4'b0100) begin bad++; $display("FAIL bounce_valor got=%b want=0100", jogada_valor); end
      botoes = 4'b0000;
      repeat (12) @(negedge clock);
   endtask

   task automatic test_multiple();
      int errs = 0;
      int jogs = 0;
      // Re-establish 0010 as the last valid move.
      botoes = 4'b0010; repeat (12) @(negedge clock);
      botoes = 4'b0000; repeat (12) @(negedge clock);
      total++; if (jogada_valor !== 4'b0010) begin bad++; $display("FAIL multi_pre got=%b want=0010", jogada_valor); end
      botoes = 4'b0011;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clock);
         if (erro_multiplo) errs++;
         if (jogada) jogs++;
         total++;
         if (erro_multiplo !== (i == 8)) begin
            bad++; $display("FAIL multi_erro cycle=%0d got=%b want=%b", i, erro_multiplo, (i == 8));
         end
      end
      total++; if (errs != 1) begin bad++; $display("FAIL multi_erro_count got=%0d want=1", errs); end
      total++; if (jogs != 0) begin bad++; $display("FAIL multi_jogada_count got=%0d want=0", jogs); end
      total++; if (jogada_valor !== 4'b0010) begin bad++; $display("FAIL multi_valor got=%b want=0010", jogada_valor); end
      botoes = 4'b0000;
      repeat (12) @(negedge clock);
   endtask

   task automatic test_hold_release();
      int pulses = 0;
      botoes = 4'b0001;
      for (int i = 0; i < 10; i++) begin @(negedge clock); if (jogada) pulses++; end
      botoes = 4'b1001;
      for (int i = 0; i < 5; i++) begin @(negedge clock); if (jogada || erro_multiplo) pulses++; end
      total++; if (db_estado !== 4'h3) begin bad++; $display("FAIL hold_db got=%h want=3", db_estado); end
      botoes = 4'b0000; @(negedge clock); if (jogada || erro_multiplo) pulses++;
      botoes = 4'b0001; @(negedge clock); if (jogada || erro_multiplo) pulses++;
      botoes = 4'b0000;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (jogada || erro_multiplo) pulses++;
         if (i == 7) begin
            total++; if (db_estado !== 4'h4) begin bad++; $display("FAIL hold_release7 got=%h want=4", db_estado); end
         end
         if (i == 8) begin
            total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL hold_release8 got=%h want=0", db_estado); end
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
      total++; if (jogada_valor !== 4'b0001) begin bad++; $display("FAIL hold_valor got=%b want=0001", jogada_valor); end
   endtask

   task automatic test_gating();
      int pulses = 0;
      int nonidle = 0;
      habilita = 1'b0;
      botoes = 4'b0100;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (jogada || erro_multiplo) pulses++;
         if (db_estado != 4'h0) nonidle++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL gate_pulses got=%0d want=0", pulses); end
      total++; if (nonidle != 0) begin bad++; $display("FAIL gate_db nonidle_cycles=%0d want=0", nonidle); end
      botoes = 4'b0000;
      repeat (3) @(negedge clock);
      habilita = 1'b1;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      botoes = 4'b1000;
      repeat (4) @(negedge clock);
      total++; if (db_estado !== 4'h1) begin bad++; $display("FAIL rmid_pre got=%h want=1", db_estado); end
      #2 reset = 1'b0;
      #1;
      total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL rmid_db got=%h want=0", db_estado); end
      total++; if (jogada_valor !== 4'b0000) begin bad++; $display("FAIL rmid_valor got=%b want=0000", jogada_valor); end
      total++; if (jogada !== 1'b0 || erro_multiplo !== 1'b0) begin
         bad++; $display("FAIL rmid_pulses got=%b%b want=00", jogada, erro_multiplo);
      end
      @(negedge clock);
      reset = 1'b1;
      // Button still held across reset release: must be captured as a new press.
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         if (jogada) pulses++;
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL rmid_newpress got=%0d want=1", pulses); end
      total++; if (jogada_valor !== 4'b1000) begin bad++; $display("FAIL rmid_newvalor got=%b want=1000", jogada_valor); end
      botoes = 4'b0000;
      repeat (12) @(negedge clock);
   endtask

   task automatic test_random();
      int cycles = 0;
      while (cycles < 1500) begin
         int r;
         int len;
         r = $urandom_range(0, 99);
         if (r < 45) botoes = 4'b0000;
         else if (r < 80) botoes = 4'b0001 << $urandom_range(0, 3);
         else botoes = 4'($urandom_range(1, 15));
         habilita = ($urandom_range(0, 9) != 0);
         len = $urandom_range(1, 10);
         for (int k = 0; k < len; k++) begin
            @(negedge clock);
            cycles++;
            total++;
            if (jogada !== exp_jogada) begin
               bad++; $display("FAIL rand_jogada t=%0t got=%b want=%b", $time, jogada, exp_jogada);
            end
            total++;
            if (erro_multiplo !== exp_erro) begin
               bad++; $display("FAIL rand_erro t=%0t got=%b want=%b", $time, erro_multiplo, exp_erro);
            end
            total++;
            if (jogada_valor !== m_valor) begin
               bad++; $display("FAIL rand_valor t=%0t got=%b want=%b", $time, jogada_valor, m_valor);
            end
            total++;
            if (jogada === 1'b1 && erro_multiplo === 1'b1) begin
               bad++; $display("FAIL rand_exclusive t=%0t got=11 want=not both", $time);
            end
         end
      end
      botoes = 4'b0000;
      habilita = 1'b1;
      repeat (12) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_multiple();
      test_hold_release();
      test_gating();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
